div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle iterative radix-2 divider for MIPS DIV/DIVU.
- Sits beside the execute stage. EX launches it, stalls the pipeline while it runs, and takes its 64-bit result into hi_o/lo_o via the HILO write path.
- Shared by signed and unsigned divide. One operation in flight at a time.

Parameters:
- None. Width is fixed at 32 bits by the ISA.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset (ENABLE = 1)
- start_i  input  1  request a divide; held by EX until it has consumed the result
- annul_i  input  1  abandon the in-flight divide (flush/exception)
- signed_div_i  input  1  1 = DIV (signed), 0 = DIVU
- dividend_i  input  32  rs operand
- divisor_i  input  32  rt operand
- result_o  output  64  {remainder, quotient}; [63:32] goes to hi, [31:0] goes to lo
- ready_o  output  1  result_o valid

Behaviour:
- Reset is synchronous, active-high, and one clock. All sampling is on the rising edge of clk.
- Reset (any state, including mid-operation): state = IDLE, counter = 0, result_o = 0, ready_o = 0. Any partial result is discarded.
- States: IDLE, BY_ZERO, ON, END.
- IDLE:
  - If start_i = 1 and annul_i = 0: latch signed_div_i, dividend_i and divisor_i.
  - If the latched divisor is 0, go to BY_ZERO; otherwise go to ON with counter = 0.
  - Inputs are not sampled again until the next IDLE.
- BY_ZERO: next edge goes to END with result_o = 0 and ready_o = 1. Divide-by-zero produces no exception.
- ON:
  - Operand preparation at entry: in signed mode, operands are replaced by their absolute values using 32-bit two's-complement negation, so 0x80000000 stays 0x80000000 when read as unsigned.
  - Each edge performs one restoring step on a 65-bit shift register {rem[32:0], quo[31:0]}:
    - shift left by 1;
    - compute trial = rem − {1'b0, divisor};
    - if trial ≥ 0, set rem = trial and quo[0] = 1.
  - counter increments each step. After the 32nd step go to END.
- Sign fix-up, applied on the transition to END in signed mode:
  - quotient is negated if dividend[31] ≠ divisor[31];
  - remainder takes the sign of the dividend.
  - Result: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
- END:
  - ready_o = 1 and result_o is held stable.
  - Stays in END while start_i = 1.
  - When start_i = 0: go to IDLE, ready_o = 0, result_o = 0.
- Latency:
  - Normal divide: ready_o rises after the 33rd rising edge following the edge that sampled start_i in IDLE.
  - Divide-by-zero: ready_o rises after the 2nd such edge.
- annul_i:
  - In BY_ZERO or ON: go to IDLE on the next edge, ready_o stays 0, nothing is written.
  - In END: go to IDLE and clear outputs, regardless of start_i.
  - In IDLE: annul_i suppresses a simultaneous start_i.
- Simultaneous events:
  - rst wins over everything, then annul_i, then start_i.
  - start_i changes while not in IDLE are ignored; operand changes mid-operation have no effect.
- EX contract:
  - EX asserts stall while (its op is DIV/DIVU) and ready_o = 0.
  - When ready_o = 1, EX drops start_i on the edge it forwards result_o to hi_o/lo_o with whilo_o = 1.
  - Back-to-back divides need at least one cycle with start_i = 0.

Test Plan:
- DIVU 7 / 2, start held → ready_o = 1 exactly 33 edges after start; result_o = {0x00000001, 0x00000003}. Holds while start_i = 1; one edge after start_i drops, ready_o = 0 and result_o = 0.
- DIV 0xFFFFFFF9 (−7) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7 / 0xFFFFFFFE → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero: DIVU 0x12345678 / 0 → ready_o = 1 after 2 edges, result_o = 0.
- Overflow corner: DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. DIVU 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- annul_i pulsed at step 10 → back in IDLE next edge, ready_o never asserts. New DIVU 100 / 7 started 1 cycle later → {2, 14} after 33 edges.
- rst asserted at step 20 with operand changes mid-operation → next edge ready_o = 0, result_o = 0, state IDLE. start_i asserted with rst still high is ignored; the first start after rst deasserts runs the full 33 edges.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU.
//
// The execute stage holds start_i until it has consumed the result. The operands are
// captured on the first IDLE edge that sees start_i. The next edge either flags a
// divide-by-zero or loads the shift register with the operand magnitudes. After that,
// 32 restoring steps run, one per edge. The sign fix-up is folded into the last step.
// ready_o stays high and result_o stays stable until start_i drops or annul_i is seen.
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   start_i       divide request, held until the result is consumed
//   annul_i       abandon the current divide (flush / exception)
//   signed_div_i  1 = DIV (signed), 0 = DIVU
//   dividend_i    rs operand
//   divisor_i     rt operand
//   result_o      {remainder, quotient}: [63:32] -> hi, [31:0] -> lo
//   ready_o       result_o valid
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_div_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {StIdle, StByZero, StOn, StEnd} state_e;

  state_e      state_q, state_d;
  // Set in IDLE once the operands are captured. The next edge decides between the
  // zero path and the divide path.
  logic        pending_q, pending_d;
  logic        signed_q, signed_d;
  logic [31:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] result_q, result_d;

  logic [31:0] dvd_abs, dsr_abs;
  logic [32:0] rem_sh;
  logic [31:0] quo_sh;
  logic [33:0] diff;
  logic [32:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] quo_fix, rem_fix;

  // Magnitudes use 32-bit negation, so 0x80000000 maps to itself.
  // That value is also the correct unsigned magnitude.
  always_comb begin
    dvd_abs = (signed_q && dividend_q[31]) ? (32'd0 - dividend_q) : dividend_q;
    dsr_abs = (signed_q && divisor_q[31])  ? (32'd0 - divisor_q)  : divisor_q;
  end

  // One restoring step on {rem, quo}.
  always_comb begin
    rem_sh = {rem_q[31:0], quo_q[31]};
    quo_sh = {quo_q[30:0], 1'b0};
    diff   = {1'b0, rem_sh} - {2'b00, dsr_abs};
    if (!diff[33]) begin
      rem_step = diff[32:0];
      quo_step = quo_sh | 32'd1;
    end else begin
      rem_step = rem_sh;
      quo_step = quo_sh;
    end
  end

  // Sign fix-up. The remainder follows the dividend's sign. The quotient is negated
  // when the operand signs differ. 0x80000000 / -1 therefore wraps to 0x80000000.
  always_comb begin
    quo_fix = (signed_q && (dividend_q[31] ^ divisor_q[31])) ? (32'd0 - quo_step) : quo_step;
    rem_fix = (signed_q && dividend_q[31]) ? (32'd0 - rem_step[31:0]) : rem_step[31:0];
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    signed_d   = signed_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    result_d   = result_q;

    unique case (state_q)
      StIdle: begin
        if (annul_i) begin
          pending_d = 1'b0;
        end else if (pending_q) begin
          pending_d = 1'b0;
          if (divisor_q == 32'd0) begin
            state_d = StByZero;
          end else begin
            state_d = StOn;
            cnt_d   = 5'd0;
            rem_d   = 33'd0;
            quo_d   = dvd_abs;
          end
        end else if (start_i) begin
          pending_d  = 1'b1;
          signed_d   = signed_div_i;
          dividend_d = dividend_i;
          divisor_d  = divisor_i;
        end
      end
      StByZero: begin
        if (annul_i) begin
          state_d = StIdle;
        end else begin
          state_d  = StEnd;
          result_d = 64'd0;
        end
      end
      StOn: begin
        if (annul_i) begin
          state_d = StIdle;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d  = StEnd;
            result_d = {rem_fix, quo_fix};
          end
        end
      end
      StEnd: begin
        if (annul_i || !start_i) begin
          state_d  = StIdle;
          result_d = 64'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pending_q  <= 1'b0;
      signed_q   <= 1'b0;
      dividend_q <= 32'd0;
      divisor_q  <= 32'd0;
      rem_q      <= 33'd0;
      quo_q      <= 32'd0;
      cnt_q      <= 5'd0;
      result_q   <= 64'd0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      signed_q   <= signed_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
    end
  end

  assign ready_o  = (state_q == StEnd);
  assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: fixed vectors, hand sequences for annul/reset, random ops vs a model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Plain-arithmetic reference: SV division truncates toward zero, as MIPS does.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Launch a divide, measure latency, scramble inputs while busy, check hold and clear.
  task automatic run_div(input string name, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int n;
    @(negedge clk);
    signed_div_i = s;
    dividend_i   = a;
    divisor_i    = b;
    start_i      = 1'b1;
    @(posedge clk);  // sampling edge
    #1;
    dividend_i   = $urandom;
    divisor_i    = $urandom;
    signed_div_i = ~s;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      dividend_i = $urandom;
      divisor_i  = $urandom;
    end while (!ready_o && n < 60);
    check({name, " latency"}, 65'(n), 65'(exp_lat));
    check({name, " result"}, {1'b0, result_o}, {1'b0, exp});
    repeat (2) begin
      @(posedge clk);
      #1;
      check({name, " hold"}, {ready_o, result_o}, {1'b1, exp});
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({name, " clear"}, {ready_o, result_o}, 65'd0);
  endtask

  // Count ready_o highs over a window with start_i low.
  task automatic watch_idle(input string name, input int cycles);
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (ready_o) hits++;
    end
    check({name, " no ready"}, 65'(hits), 65'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'd7,        32'd2,        {32'd1, 32'd3},                33};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD},  33};
    vecs[2]  = '{1'b1, 32'd7,        32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD},         33};
    vecs[3]  = '{1'b0, 32'h12345678, 32'd0,        64'd0,                         2};
    vecs[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000},         33};
    vecs[5]  = '{1'b0, 32'hFFFFFFFF, 32'd1,        {32'd0, 32'hFFFFFFFF},         33};
    vecs[6]  = '{1'b0, 32'd100,      32'd7,        {32'd2, 32'd14},               33};
    vecs[7]  = '{1'b1, 32'hFFFFFFF9, 32'd0,        64'd0,                         2};
    vecs[8]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0},         33};
    vecs[9]  = '{1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, {32'hFFFFFFFE, 32'd2},         33};
    vecs[10] = '{1'b1, 32'h80000000, 32'd1,        {32'd0, 32'h80000000},         33};

    rst          = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    dividend_i   = 32'd0;
    divisor_i    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset state", {ready_o, result_o}, 65'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp,
              vecs[i].lat);
    end

    // annul at step 10, then a new divide one cycle later
    @(negedge clk);
    signed_div_i = 1'b0;
    dividend_i   = 32'd1000;
    divisor_i    = 32'd3;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("annul on", {ready_o, result_o}, 65'd0);
    @(negedge clk);
    annul_i = 1'b0;
    run_div("after annul", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

    // reset at step 20 with operand changes; start during reset ignored
    @(negedge clk);
    dividend_i = 32'hDEADBEEF;
    divisor_i  = 32'h1234;
    start_i    = 1'b1;
    @(posedge clk);
    repeat (21) @(posedge clk);
    @(negedge clk);
    dividend_i = 32'd5;
    divisor_i  = 32'd0;
    rst        = 1'b1;
    @(posedge clk);
    #1;
    check("rst mid-op", {ready_o, result_o}, 65'd0);
    @(posedge clk);
    #1;
    check("start in rst", {ready_o, result_o}, 65'd0);
    @(negedge clk);
    rst     = 1'b0;
    start_i = 1'b0;
    watch_idle("after rst", 40);
    run_div("first after rst", 1'b0, 32'hDEADBEEF, 32'h1234,
            model(1'b0, 32'hDEADBEEF, 32'h1234), 33);

    // annul suppresses a simultaneous start in IDLE
    @(negedge clk);
    start_i    = 1'b1;
    annul_i    = 1'b1;
    dividend_i = 32'd9;
    divisor_i  = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;
    watch_idle("annul idle", 40);

    // annul in END clears even with start held; divide-by-zero annulled in BY_ZERO
    @(negedge clk);
    dividend_i = 32'd50;
    divisor_i  = 32'd5;
    start_i    = 1'b1;
    begin
      int n;
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!ready_o && n < 60);
      check("end reached", {1'b0, result_o}, {1'b0, 32'd0, 32'd10});
    end
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("annul end", {ready_o, result_o}, 65'd0);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    divisor_i = 32'd0;
    start_i   = 1'b1;
    @(negedge clk);  // latched
    @(negedge clk);  // in BY_ZERO
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    watch_idle("annul by zero", 10);

    // random operations against the model
    for (int i = 0; i < 40; i++) begin
      logic        s;
      logic [31:0] a, b;
      int          sel;
      s   = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = 32'd0;
      else if (sel == 1) b = 32'hFFFFFFFF;
      else if (sel == 2) b = 32'($urandom_range(1, 16));
      else               b = $urandom;
      run_div($sformatf("rand%0d", i), s, a, b, model(s, a, b), (b == 32'd0) ? 2 : 33);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
